fp_norm_32: RTL and testbench
=============================

Name: fp_norm_32

Overview:
- Pipelined post-arithmetic normaliser for the FPU datapath.
- Takes an unnormalised 32-bit mantissa and a signed exponent, and counts leading zeros with an lzc_32 instance.
- Left-shifts the mantissa so bit 31 is set and reduces the exponent by the shift amount.
- Sits between the adder/multiplier significand stage and the rounding stage; 2-stage pipeline with valid/ready backpressure.

Parameters:
- EXP_W, 10: exponent width, two's complement signed.
- EMIN, -126: minimum normal exponent (signed). Constraint: EMIN-31 >= -2^(EXP_W-1).
- TAG_W, 4: width of sideband tag carried alongside each operand.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline kill
- in_valid  input  1  operand valid
- in_ready  output  1  block accepts operand this cycle
- in_mant  input  32  unnormalised mantissa
- in_exp  input  EXP_W  signed exponent
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_mant  output  32  normalised mantissa
- out_exp  output  EXP_W  adjusted signed exponent
- out_tag  output  TAG_W  tag of the operand
- out_zero  output  1  input mantissa was zero
- out_tiny  output  1  true exponent fell below EMIN

Behaviour:
- Reset is asserted while reset=0, asynchronously. All stage valid bits clear and all data registers go to 0, so every output is 0 during reset. Data registers hold 0 until first load.
- Stage 1 (S1):
  - Registers in_mant, in_exp, in_tag.
  - Registers the lzc_32 count c (5 bits) and zero = ~v of in_mant.
- Stage 2 (S2):
  - shift = c. mant = S1.mant << shift.
  - exp = S1.exp - shift, computed in EXP_W+1 bits, then truncated. The EMIN constraint guarantees no wrap.
  - tiny = (S1.exp - c) < EMIN, signed compare.
  - zero operand: mant=0, exp=0, tiny=0, zero=1. The lzc count is ignored in this case.
- Latency: 2 cycles from accepted input to out_valid when there is no backpressure. Throughput is 1 operand per cycle.
- Handshake:
  - adv2 = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | adv2.
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - S1 loads on input transfer. Otherwise S1 clears its valid when S1 moves to S2; otherwise it holds.
  - S2 loads from S1 when adv2. s2_valid becomes s1_valid in that case.
- Stall: while out_valid=1 and out_ready=0, S2 holds all outputs stable. S1 holds too if valid, and in_ready=0 only when both stages are occupied.
- Simultaneous accept and emit in the same cycle pipelines normally, with no bubble.
- out_* data are registered and are don't-care while out_valid=0 (the bench must not check them).
- flush=1:
  - Next edge clears s1_valid and s2_valid.
  - Any same-cycle input transfer is discarded.
  - in_ready is still computed normally.
  - Data registers may update.
- Reset mid-operation: in-flight operands are lost. out_valid=0 immediately (asynchronous).
- in_ready never depends combinationally on in_valid.

Optional Feature:
FP_NORM_DENORM_EN
- Defined (gradual underflow):
  - If S1.exp - c < EMIN and the operand is nonzero: shift = max(S1.exp - EMIN, 0), out_exp = EMIN, out_tiny=1.
  - The mantissa is left partially normalised, i.e. a subnormal.
  - If S1.exp < EMIN already: shift=0, out_exp=S1.exp, out_tiny=1.
  - Otherwise the behaviour is identical to the macro being undefined.
- Undefined: full shift by c is always applied, and out_tiny is only a flag.
- Zero handling and the handshake are unchanged either way.

Test Plan:
- Mantissa and exponent adjust: in_mant=0x0000_1234, in_exp=10, tag=3, out_ready=1 -> 2 cycles later: out_mant=0x91A0_0000, out_exp=-9, out_tag=3, zero=0, tiny=0.
- Zero operand: in_mant=0, in_exp=50 -> out_mant=0, out_exp=0, out_zero=1.
- Tiny, macro undefined: in_mant=0x0000_0001, in_exp=-120 -> out_mant=0x8000_0000, out_exp=-151, out_tiny=1.
- Tiny, macro defined (same stimulus) -> shift 6, out_mant=0x0000_0040, out_exp=-126, out_tiny=1.
- Backpressure and flush:
  - Stream 4 tagged operands; hold out_ready=0 for 3 cycles starting when the first result is valid.
  - Required: in_ready=0 once both stages are full, outputs stable while stalled, all 4 results delivered in order with no loss or duplication.
  - Then assert flush with 2 operands in flight: out_valid=0 on the next cycle and neither result emerges.
- Reset: assert reset=0 mid-stream -> out_valid=0 and in_ready=0 asynchronously. After reset=1, in_ready=1 and the first new operand emerges after exactly 2 cycles.

Source files
------------

// File: rtl/fp_norm_32.sv
// Two-stage post-arithmetic normaliser: leading-zero count, left shift, exponent adjust.
// Define FP_NORM_DENORM_EN for gradual underflow (subnormal output clamped to EMIN).

module lzc_32 (
   input  logic [31:0] data,
   output logic [4:0]  count,
   output logic        valid
);

   always_comb begin
      count = '0;
      valid = |data;
      // ascending scan: the highest set bit is written last and wins
      for (int unsigned i = 0; i < 32; i++) begin
         if (data[i]) count = 5'(31 - i);
      end
   end

endmodule

module fp_norm_32 #(
   parameter int EXP_W = 10,
   parameter int EMIN  = -126,
   parameter int TAG_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_mant,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_mant,
   output logic [EXP_W-1:0] out_exp,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero,
   output logic             out_tiny
);

   localparam logic signed [EXP_W:0] EMIN_X = (EXP_W+1)'(EMIN);

   logic [4:0]       lzc_count;
   logic             lzc_valid;
   logic             adv2;
   logic             in_xfer;

   logic             s1_valid;
   logic [31:0]      s1_mant;
   logic [EXP_W-1:0] s1_exp;
   logic [TAG_W-1:0] s1_tag;
   logic [4:0]       s1_cnt;
   logic             s1_zero;

   logic             s2_valid;
   logic [31:0]      s2_mant;
   logic [EXP_W-1:0] s2_exp;
   logic [TAG_W-1:0] s2_tag;
   logic             s2_zero;
   logic             s2_tiny;

   logic signed [EXP_W:0] exp_x;
   logic signed [EXP_W:0] cnt_x;
   logic signed [EXP_W:0] diff_x;
   logic                  tiny_raw;
   logic [4:0]            shift;
   logic [31:0]           nx_mant;
   logic [EXP_W-1:0]      nx_exp;
   logic                  nx_tiny;

   lzc_32 u_lzc (
      .data  (in_mant),
      .count (lzc_count),
      .valid (lzc_valid)
   );

   assign adv2     = ~s2_valid | out_ready;
   // gated by reset so the block refuses operands while held in reset
   assign in_ready = reset & (~s1_valid | adv2);
   assign in_xfer  = in_valid & in_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_mant  <= '0;
         s1_exp   <= '0;
         s1_tag   <= '0;
         s1_cnt   <= '0;
         s1_zero  <= 1'b0;
      end else begin
         if (in_xfer) begin
            s1_mant <= in_mant;
            s1_exp  <= in_exp;
            s1_tag  <= in_tag;
            s1_cnt  <= lzc_count;
            s1_zero <= ~lzc_valid;
         end
         if (flush)        s1_valid <= 1'b0;
         else if (in_xfer) s1_valid <= 1'b1;
         else if (adv2)    s1_valid <= 1'b0;
      end
   end

   assign exp_x    = {s1_exp[EXP_W-1], s1_exp};
   assign cnt_x    = (EXP_W+1)'(s1_cnt);
   assign diff_x   = exp_x - cnt_x;
   assign tiny_raw = diff_x < EMIN_X;

   always_comb begin
      shift   = s1_cnt;
      nx_exp  = diff_x[EXP_W-1:0];
      nx_tiny = tiny_raw;
`ifdef FP_NORM_DENORM_EN
      // stop shifting at EMIN; operands already below EMIN stay unshifted
      if (tiny_raw) begin
         if (exp_x < EMIN_X) begin
            shift  = '0;
            nx_exp = s1_exp;
         end else begin
            shift  = 5'(exp_x - EMIN_X);
            nx_exp = EMIN_X[EXP_W-1:0];
         end
      end
`endif
      nx_mant = s1_mant << shift;
      if (s1_zero) begin
         nx_mant = '0;
         nx_exp  = '0;
         nx_tiny = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_mant  <= '0;
         s2_exp   <= '0;
         s2_tag   <= '0;
         s2_zero  <= 1'b0;
         s2_tiny  <= 1'b0;
      end else begin
         if (adv2) begin
            s2_mant <= nx_mant;
            s2_exp  <= nx_exp;
            s2_tag  <= s1_tag;
            s2_zero <= s1_zero;
            s2_tiny <= nx_tiny;
         end
         if (flush)     s2_valid <= 1'b0;
         else if (adv2) s2_valid <= s1_valid;
      end
   end

   assign out_valid = s2_valid;
   assign out_mant  = s2_mant;
   assign out_exp   = s2_exp;
   assign out_tag   = s2_tag;
   assign out_zero  = s2_zero;
   assign out_tiny  = s2_tiny;

endmodule

// File: tb/tb_fp_norm_32.sv
// Self-checking bench for fp_norm_32: directed vectors plus a result-queue model
// checked against every valid output cycle.

module tb_fp_norm_32;

   localparam int EXP_W = 10;
   localparam int EMIN  = -126;
   localparam int TAG_W = 4;

   logic             clock, reset, flush;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [31:0]      in_mant, out_mant;
   logic [EXP_W-1:0] in_exp, out_exp;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic             out_zero, out_tiny;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;

   typedef struct packed {
      logic [31:0]      mant;
      logic [EXP_W-1:0] exp;
      logic [TAG_W-1:0] tag;
      logic             zero;
      logic             tiny;
   } res_t;

   res_t exp_q[$];

   fp_norm_32 #(.EXP_W(EXP_W), .EMIN(EMIN), .TAG_W(TAG_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mant   (in_mant),
      .in_exp    (in_exp),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mant  (out_mant),
      .out_exp   (out_exp),
      .out_tag   (out_tag),
      .out_zero  (out_zero),
      .out_tiny  (out_tiny)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Normalisation from first principles: find the leading one, shift it to bit 31.
   function automatic res_t model(input logic [31:0] m, input int e, input logic [TAG_W-1:0] t);
      res_t r;
      int   lz;
      int   sh;
      int   ne;
      r.tag = t;
      if (m == 32'd0) begin
         r.mant = '0;
         r.exp  = '0;
         r.zero = 1'b1;
         r.tiny = 1'b0;
         return r;
      end
      lz = 0;
      while (m[31-lz] == 1'b0) lz++;
      sh     = lz;
      ne     = e - lz;
      r.tiny = (ne < EMIN);
`ifdef FP_NORM_DENORM_EN
      if (ne < EMIN) begin
         if (e < EMIN) begin
            sh = 0;
            ne = e;
         end else begin
            sh = e - EMIN;
            ne = EMIN;
         end
      end
`endif
      r.mant = m << sh;
      r.exp  = EXP_W'(ne);
      r.zero = 1'b0;
      return r;
   endfunction

   always @(negedge clock) begin
      res_t got;
      if (!reset) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            got = {out_mant, out_exp, out_tag, out_zero, out_tiny};
            if (exp_q.size() == 0) begin
               check("out_spurious", 64'(exp_q.size()), 64'd1);
            end else begin
               check("out", 64'(got), 64'(exp_q[0]));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  n_out++;
               end
            end
         end
         if (flush) exp_q.delete();
         else if (in_valid && in_ready)
            exp_q.push_back(model(in_mant, int'($signed(in_exp)), in_tag));
      end
   end

   task automatic send(input logic [31:0] m, input int e, input logic [TAG_W-1:0] t, output int waited);
      in_valid = 1'b1;
      in_mant  = m;
      in_exp   = EXP_W'(e);
      in_tag   = t;
      waited   = 0;
      @(negedge clock);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clock);
      end
      if (!in_ready) check("send_timeout", 64'(waited), 64'd0);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         @(posedge clock);
         k++;
      end
      #1;
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int   w;
      int   base;
      bit   saw_block;
      res_t m;

      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_mant = '0; in_exp = '0; in_tag = '0;

      // reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_outputs", 64'({out_mant, out_exp, out_tag, out_zero, out_tiny}), 64'd0);
      reset = 1'b1;
      #1;
      check("rel_in_ready", 64'(in_ready), 64'd1);

      // pin the model against hand-computed results
      m = model(32'h0000_1234, 10, 4'd3);
      check("model_t1", 64'(m), 64'({32'h91A0_0000, 10'h3F7, 4'd3, 1'b0, 1'b0}));
      m = model(32'h0000_0000, 50, 4'd5);
      check("model_zero", 64'(m), 64'({32'h0, 10'h000, 4'd5, 1'b1, 1'b0}));
      m = model(32'h0000_0001, -120, 4'd7);
`ifdef FP_NORM_DENORM_EN
      check("model_tiny", 64'(m), 64'({32'h0000_0040, 10'h382, 4'd7, 1'b0, 1'b1}));
`else
      check("model_tiny", 64'(m), 64'({32'h8000_0000, 10'h369, 4'd7, 1'b0, 1'b1}));
`endif

      // directed: mantissa/exponent adjust, 2-cycle latency
      @(posedge clock); #1;
      send(32'h0000_1234, 10, 4'd3, w);
      check("t1_wait", 64'(w), 64'd0);
      check("t1_lat1_valid", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_mant", 64'(out_mant), 64'h91A0_0000);
      check("t1_exp", 64'(out_exp), 64'h3F7);
      check("t1_tag", 64'(out_tag), 64'd3);
      check("t1_flags", 64'({out_zero, out_tiny}), 64'd0);

      // zero operand
      send(32'h0000_0000, 50, 4'd5, w);
      @(posedge clock); #1;
      check("zero_valid", 64'(out_valid), 64'd1);
      check("zero_mant_exp", 64'({out_mant, out_exp}), 64'd0);
      check("zero_flag", 64'(out_zero), 64'd1);

      // tiny result
      send(32'h0000_0001, -120, 4'd7, w);
      @(posedge clock); #1;
      check("tiny_valid", 64'(out_valid), 64'd1);
`ifdef FP_NORM_DENORM_EN
      check("tiny_mant", 64'(out_mant), 64'h0000_0040);
      check("tiny_exp", 64'(out_exp), 64'h382);
`else
      check("tiny_mant", 64'(out_mant), 64'h8000_0000);
      check("tiny_exp", 64'(out_exp), 64'h369);
`endif
      check("tiny_flag", 64'(out_tiny), 64'd1);

      // back-to-back stream of boundary vectors, full throughput expected
      send(32'h0001_0000, -130, 4'd1, w); check("bb_wait0", 64'(w), 64'd0);
      send(32'h00F0_0000, -120, 4'd2, w); check("bb_wait1", 64'(w), 64'd0);
      send(32'h0080_0000, -118, 4'd4, w); check("bb_wait2", 64'(w), 64'd0);
      send(32'h8000_0000,    0, 4'd6, w); check("bb_wait3", 64'(w), 64'd0);
      send(32'hFFFF_FFFF,   -3, 4'd9, w); check("bb_wait4", 64'(w), 64'd0);
      send(32'h0000_0002,  300, 4'd10, w); check("bb_wait5", 64'(w), 64'd0);
      drain("bb_drain");

      // backpressure: 4 operands, out_ready low for 3 cycles from first result
      base = n_out;
      saw_block = 1'b0;
      @(posedge clock); #1;
      fork
         begin
            for (int i = 0; i < 4; i++) send(32'h0000_0100 << i, i, TAG_W'(8 + i), w);
         end
         begin
            int k;
            k = 0;
            while (!out_valid && k < 50) begin
               @(posedge clock); #1;
               k++;
            end
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clock);
               if (!in_ready) saw_block = 1'b1;
            end
            @(posedge clock); #1;
            out_ready = 1'b1;
         end
      join
      drain("bp_drain");
      check("bp_in_ready_low", 64'(saw_block), 64'd1);
      check("bp_delivered", 64'(n_out - base), 64'd4);

      // flush with both stages occupied and stalled
      out_ready = 1'b0;
      send(32'h0000_0010, 1, 4'd1, w);
      send(32'h0000_0020, 2, 4'd2, w);
      check("fl_full_valid", 64'(out_valid), 64'd1);
      check("fl_full_in_ready", 64'(in_ready), 64'd0);
      flush = 1'b1;
      in_valid = 1'b1; in_mant = 32'h0000_0030; in_exp = 10'd3; in_tag = 4'd3;
      @(posedge clock); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("fl_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("fl_quiet", 64'(out_valid), 64'd0);

      // flush discards a same-cycle input transfer
      in_valid = 1'b1; in_mant = 32'h0000_0040; in_exp = 10'd4; in_tag = 4'd4;
      flush = 1'b1;
      #1;
      check("fl_ready_during_flush", 64'(in_ready), 64'd1);
      @(posedge clock); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(posedge clock); #1;
      check("fl_drop_c1", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
      check("fl_drop_c2", 64'(out_valid), 64'd0);

      // asynchronous reset mid-stream
      in_valid = 1'b1; in_mant = 32'h0000_0003; in_exp = 10'd0; in_tag = 4'd1;
      repeat (3) begin
         @(posedge clock); #1;
         in_tag = in_tag + 4'd1;
      end
      check("mid_pre_valid", 64'(out_valid), 64'd1);
      #3;
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      check("mid_rel_in_ready", 64'(in_ready), 64'd1);
      send(32'h0000_8000, 5, 4'd12, w);
      check("post_lat1_valid", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
      check("post_valid", 64'(out_valid), 64'd1);
      check("post_mant", 64'(out_mant), 64'h8000_0000);
      check("post_exp", 64'(out_exp), 64'h3F5);
      check("post_tag", 64'(out_tag), 64'd12);
      drain("final_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
